// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_issue_ctrl
// Brief    : Decode-stage issue/hazard control with a shift-register scoreboard
//            and a multi-cycle multiply sequencer.
// Revision : 1.0
// ============================================================================
module pipe_issue_ctrl #(
  parameter int unsigned DEPTH      = 3,
  parameter logic [7:0]  MUL_OP     = 8'h07,
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [7:0] id_op,
  input  logic [7:0] id_a,
  input  logic [7:0] id_b,
  input  logic [7:0] id_c,
  input  logic       flush,
  output logic       stall,
  output logic       issue,
  output logic       bubble,
  output logic       mc_busy,
  output logic [7:0] mc_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam logic [7:0] MC_INIT  = 8'(MUL_CYCLES - 1);
  localparam bit         IS_MULTI = (MUL_CYCLES > 1);

  state_e                    state_q, state_d;
  logic [7:0]                mc_count_q, mc_count_d;
  logic [7:0]                mc_dest_q, mc_dest_d;
  logic [DEPTH-1:0]          sb_v_q, sb_v_d;
  logic [DEPTH-1:0][7:0]     sb_dest_q, sb_dest_d;

  logic                      sb0_v;
  logic [7:0]                sb0_dest;
  logic [DEPTH-2:0]          match_b, match_c;
  logic                      busy;
  logic                      reads_src;
  logic                      writes_dest;
  logic                      haz_b, haz_c, hazard;
  logic                      unused_retire;

  // The writeback stage sb[DEPTH-1] is excluded: its value is available this cycle.
  generate
    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_match
      assign match_b[i] = sb_v_q[i] && (sb_dest_q[i] == id_b);
      assign match_c[i] = sb_v_q[i] && (sb_dest_q[i] == id_c);
    end
  endgenerate

  assign busy        = (state_q == BUSY);
  assign reads_src   = (id_op != 8'h00);
  assign writes_dest = (id_op != 8'h00) && !id_op[7] && (id_a != 8'h00);
  assign haz_b       = (id_b != 8'h00) && ((|match_b) || (busy && (mc_dest_q == id_b)));
  assign haz_c       = (id_c != 8'h00) && ((|match_c) || (busy && (mc_dest_q == id_c)));
  assign hazard      = reads_src && (haz_b || haz_c);

  always_comb begin
    state_d    = state_q;
    mc_count_d = mc_count_q;
    mc_dest_d  = mc_dest_q;
    sb0_v      = 1'b0;
    sb0_dest   = id_a;
    issue      = 1'b0;

    case (state_q)
      IDLE: begin
        issue = rst_n && id_valid && !hazard && !flush;
        if (issue) begin
          if (IS_MULTI && (id_op == MUL_OP)) begin
            state_d    = BUSY;
            mc_count_d = MC_INIT;
            mc_dest_d  = id_op[7] ? 8'h00 : id_a;
          end else begin
            sb0_v = writes_dest;
          end
        end
      end
      BUSY: begin
        mc_count_d = mc_count_q - 8'd1;
        // Multiply result enters the scoreboard in its last busy cycle.
        if (mc_count_q == 8'd1) begin
          state_d  = IDLE;
          sb0_v    = (mc_dest_q != 8'h00);
          sb0_dest = mc_dest_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d    = IDLE;
      mc_count_d = 8'h00;
      mc_dest_d  = 8'h00;
    end

    sb_v_d    = flush ? '0 : {sb_v_q[DEPTH-2:0], sb0_v};
    sb_dest_d = {sb_dest_q[DEPTH-2:0], sb0_dest};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mc_count_q <= 8'h00;
      mc_dest_q  <= 8'h00;
      sb_v_q     <= '0;
      sb_dest_q  <= '0;
    end else begin
      state_q    <= state_d;
      mc_count_q <= mc_count_d;
      mc_dest_q  <= mc_dest_d;
      sb_v_q     <= sb_v_d;
      sb_dest_q  <= sb_dest_d;
    end
  end

  // Outputs are forced low while reset is held.
  assign stall    = rst_n && id_valid && !issue && !flush;
  assign bubble   = rst_n && !issue;
  assign mc_busy  = busy;
  assign mc_count = mc_count_q;

  assign unused_retire = ^{sb_v_q[DEPTH-1], sb_dest_q[DEPTH-1]};

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_issue_ctrl
// Brief    : Directed vector bench for pipe_issue_ctrl (DEPTH=3, MUL_CYCLES=4).
// Revision : 1.0
// ============================================================================
module tb_pipe_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [7:0] id_op, id_a, id_b, id_c;
  logic       flush;
  logic       stall, issue, bubble, mc_busy;
  logic [7:0] mc_count;

  int checks = 0;
  int errors = 0;

  pipe_issue_ctrl #(
    .DEPTH      (3),
    .MUL_OP     (8'h07),
    .MUL_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .id_valid (id_valid),
    .id_op    (id_op),
    .id_a     (id_a),
    .id_b     (id_b),
    .id_c     (id_c),
    .flush    (flush),
    .stall    (stall),
    .issue    (issue),
    .bubble   (bubble),
    .mc_busy  (mc_busy),
    .mc_count (mc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] op, a, b, c;
    logic       fl;
    logic       e_stall, e_issue, e_bubble, e_busy;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic fl);
    id_valid = v; id_op = op; id_a = a; id_b = b; id_c = c; flush = fl;
  endtask

  task automatic check_all(input int idx, input logic e_st, input logic e_is,
                           input logic e_bu, input logic e_mb, input logic [7:0] e_cnt);
    chk("stall",    idx, {7'd0, stall},   {7'd0, e_st});
    chk("issue",    idx, {7'd0, issue},   {7'd0, e_is});
    chk("bubble",   idx, {7'd0, bubble},  {7'd0, e_bu});
    chk("mc_busy",  idx, {7'd0, mc_busy}, {7'd0, e_mb});
    chk("mc_count", idx, mc_count,        e_cnt);
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c, input logic fl,
                              input logic st, input logic is, input logic bu,
                              input logic mb, input logic [7:0] cnt);
    vec_t r;
    r.v = v; r.op = op; r.a = a; r.b = b; r.c = c; r.fl = fl;
    r.e_stall = st; r.e_issue = is; r.e_bubble = bu; r.e_busy = mb; r.e_cnt = cnt;
    return r;
  endfunction

  initial begin
    //                    v  op     a      b      c      fl   st is bu mb cnt
    // RAW on r5
    vecs.push_back(mk(1, 8'h01, 8'd5, 8'd0, 8'd0, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd7, 8'd5, 8'd6, 0,   1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd7, 8'd5, 8'd6, 0,   1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd7, 8'd5, 8'd6, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 8'd0, 0,   0, 0, 1, 0, 8'd0));
    vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 8'd0, 0,   0, 0, 1, 0, 8'd0));
    // independent stream; first row reads r7 while it sits in writeback
    vecs.push_back(mk(1, 8'h01, 8'd1, 8'd7, 8'd8, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h03, 8'd2, 8'd7, 8'd8, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h04, 8'd3, 8'd7, 8'd8, 0,   0, 1, 0, 0, 8'd0));
    // register 0, no-dest op, NOP ignoring sources
    vecs.push_back(mk(1, 8'h01, 8'd0, 8'd0, 8'd0, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd0, 8'd0, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h85, 8'd4, 8'd1, 8'd1, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd5, 8'd4, 8'd4, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h00, 8'd0, 8'd5, 8'd5, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(0, 8'h00, 8'd0, 8'd0, 8'd0, 0,   0, 0, 1, 0, 8'd0));
    // multiply into r9, dependent op waits for writeback
    vecs.push_back(mk(1, 8'h07, 8'd9, 8'd0, 8'd0, 0,   0, 1, 0, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   1, 0, 1, 1, 8'd3));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   1, 0, 1, 1, 8'd2));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   1, 0, 1, 1, 8'd1));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   0, 1, 0, 0, 8'd0));
    // multiply with a source hazard stalls in IDLE
    vecs.push_back(mk(1, 8'h07, 8'd9, 8'd6, 8'd0, 0,   1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h07, 8'd9, 8'd6, 8'd0, 0,   1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h07, 8'd9, 8'd6, 8'd0, 0,   0, 1, 0, 0, 8'd0));
    // flush in second busy cycle
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   1, 0, 1, 1, 8'd3));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 1,   0, 0, 1, 1, 8'd2));
    vecs.push_back(mk(1, 8'h02, 8'd6, 8'd9, 8'd0, 0,   0, 1, 0, 0, 8'd0));
    // flush clears scoreboard entries
    vecs.push_back(mk(1, 8'h02, 8'd7, 8'd6, 8'd0, 0,   1, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd7, 8'd6, 8'd0, 1,   0, 0, 1, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 8'd7, 8'd6, 8'd0, 0,   0, 1, 0, 0, 8'd0));

    rst_n = 1'b0;
    drive(1, 8'h02, 8'd3, 8'd0, 8'd0, 0);
    #12;
    check_all(-1, 0, 0, 0, 0, 8'd0);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].fl);
      #4 check_all(i, vecs[i].e_stall, vecs[i].e_issue, vecs[i].e_bubble,
                   vecs[i].e_busy, vecs[i].e_cnt);
    end

    // Asynchronous reset in the middle of a multiply
    @(posedge clk);
    #1 drive(1, 8'h07, 8'd9, 8'd0, 8'd0, 0);
    #4 check_all(100, 0, 1, 0, 0, 8'd0);
    @(posedge clk);
    #1 drive(1, 8'h02, 8'd6, 8'd9, 8'd0, 0);
    #4 check_all(101, 1, 0, 1, 1, 8'd3);
    #1 rst_n = 1'b0;
    #1 check_all(102, 0, 0, 0, 0, 8'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 8'h01, 8'd3, 8'd9, 8'd0, 0);
    #2 check_all(103, 0, 1, 0, 0, 8'd0);

    @(posedge clk);
    #1 drive(0, 8'h00, 8'd0, 8'd0, 8'd0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
